// File: rtl/insn_decode_queue.sv
// Buffered instruction decode queue: DEPTH-entry FIFO of raw words, head presented fully decoded.
// Optional DECODE_STATS_EN adds push and illegal-pop counters.
module insn_decode_queue #(
    parameter int INSN_WIDTH   = 32,
    parameter int OPCODE_WIDTH = 5,
    parameter int REG_WIDTH    = 5,
    parameter int XLEN         = 32,
    parameter int DEPTH        = 4
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               flush,
    input  logic                               in_valid,
    input  logic [INSN_WIDTH-1:0]              in_insn,
    output logic                               in_ready,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [OPCODE_WIDTH-1:0]            opcode,
    output logic [REG_WIDTH-1:0]               rd,
    output logic [REG_WIDTH-1:0]               rs,
    output logic [REG_WIDTH-1:0]               rt,
    output logic [REG_WIDTH-1:0]               shamt,
    output logic [REG_WIDTH-1:0]               aluop,
    output logic [XLEN-1:0]                    imm_sext,
    output logic [INSN_WIDTH-OPCODE_WIDTH-1:0] target,
    output logic [1:0]                         fmt,
`ifdef DECODE_STATS_EN
    output logic [31:0]                        stat_accepted,
    output logic [31:0]                        stat_illegal,
`endif
    output logic                               illegal
);
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;
    localparam int OP_LO = INSN_WIDTH - OPCODE_WIDTH;
    localparam int IMM   = INSN_WIDTH - OPCODE_WIDTH - 2*REG_WIDTH;

    localparam logic [1:0] FMT_R   = 2'd0;
    localparam logic [1:0] FMT_I   = 2'd1;
    localparam logic [1:0] FMT_JI  = 2'd2;
    localparam logic [1:0] FMT_JII = 2'd3;

    logic [INSN_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wptr, r_rptr;
    logic [CW-1:0]         r_count;
    logic                  w_push, w_pop;
    logic [INSN_WIDTH-1:0] w_head;

    assign in_ready  = (r_count < CW'(DEPTH));
    assign out_valid = (r_count != '0);
    // Flush wins: a same-cycle push or pop is discarded.
    assign w_push = in_valid & in_ready & ~flush;
    assign w_pop  = out_valid & out_ready & ~flush;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= in_insn;
                r_wptr        <= r_wptr + PW'(1);
            end
            if (w_pop) r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head   = r_mem[r_rptr];
    assign opcode   = w_head[INSN_WIDTH-1 -: OPCODE_WIDTH];
    assign rd       = w_head[OP_LO-1 -: REG_WIDTH];
    assign rs       = w_head[OP_LO-1-REG_WIDTH -: REG_WIDTH];
    assign rt       = w_head[OP_LO-1-2*REG_WIDTH -: REG_WIDTH];
    assign shamt    = w_head[OP_LO-1-3*REG_WIDTH -: REG_WIDTH];
    assign aluop    = w_head[OP_LO-1-4*REG_WIDTH -: REG_WIDTH];
    assign imm_sext = {{(XLEN-IMM){w_head[IMM-1]}}, w_head[IMM-1:0]};
    assign target   = w_head[OP_LO-1:0];

    always_comb begin
        fmt     = FMT_R;
        illegal = 1'b0;
        case (opcode)
            OPCODE_WIDTH'(5'b00000): fmt = FMT_R;
            OPCODE_WIDTH'(5'b00010), OPCODE_WIDTH'(5'b00101), OPCODE_WIDTH'(5'b00110),
            OPCODE_WIDTH'(5'b00111), OPCODE_WIDTH'(5'b01000): fmt = FMT_I;
            OPCODE_WIDTH'(5'b00001), OPCODE_WIDTH'(5'b00011), OPCODE_WIDTH'(5'b10101),
            OPCODE_WIDTH'(5'b10110): fmt = FMT_JI;
            OPCODE_WIDTH'(5'b00100): fmt = FMT_JII;
            default: illegal = 1'b1;
        endcase
    end

`ifdef DECODE_STATS_EN
    // Counters survive flush; only reset clears them.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_accepted <= '0;
            stat_illegal  <= '0;
        end else begin
            if (w_push)           stat_accepted <= stat_accepted + 32'd1;
            if (w_pop && illegal) stat_illegal  <= stat_illegal + 32'd1;
        end
    end
`endif
endmodule

// File: doc/insn_decode_queue.md
Name: insn_decode_queue

Overview:
- Parametrised, buffered successor to the combinational instruction splitter.
- Accepts raw instruction words over a valid/ready handshake and holds them in a DEPTH-entry FIFO.
- Presents the head entry fully decoded: fields, sign-extended immediate, format class and illegal-opcode flag.
- Sits between instruction fetch and the decode/regfile-read stage; absorbs stalls and supports flush on branch/jump redirect.

Parameters:
- INSN_WIDTH, 32, instruction word width.
- OPCODE_WIDTH, 5, opcode field width (MSBs).
- REG_WIDTH, 5, width of rd/rs/rt/shamt/aluop fields.
- XLEN, 32, width of sign-extended immediate output.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous queue clear.
- in_valid  in  1  instruction offered.
- in_insn  in  INSN_WIDTH  raw instruction.
- in_ready  out  1  queue can accept.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes head.
- opcode  out  OPCODE_WIDTH  bits [W-1 -: OPCODE_WIDTH].
- rd  out  REG_WIDTH  next field below opcode.
- rs  out  REG_WIDTH  next field below rd.
- rt  out  REG_WIDTH  next field below rs.
- shamt  out  REG_WIDTH  next field below rt.
- aluop  out  REG_WIDTH  next field below shamt.
- imm_sext  out  XLEN  low IMM = INSN_WIDTH-OPCODE_WIDTH-2*REG_WIDTH bits (17 at defaults), sign-extended.
- target  out  INSN_WIDTH-OPCODE_WIDTH  low bits, zero-extended (27 at defaults).
- fmt  out  2  format class: 0=R, 1=I, 2=JI, 3=JII.
- illegal  out  1  opcode not in table.

Behaviour:
- Reset (reset=0, async):
  - Storage, pointers and count cleared.
  - out_valid=0, in_ready=1.
  - Head decodes word 0: all fields 0, fmt=R, illegal=0.
- Push: in_valid & in_ready at a rising edge writes in_insn at the write pointer.
- Pop: out_valid & out_ready at a rising edge advances the read pointer.
- Pointers wrap modulo DEPTH.
- in_ready = (count < DEPTH), registered-state only; no combinational path from out_ready.
- out_valid = (count != 0).
- Latency: a word pushed at edge N is visible on the outputs from the cycle after edge N when the queue was empty.
- Full (count=DEPTH): in_ready=0 even if a pop occurs the same cycle.
- Empty: out_valid=0; out_ready is ignored and the pointer does not move.
- Simultaneous push and pop when 0<count<DEPTH: count unchanged, both pointers advance.
- flush=1 at an edge:
  - count and pointers reset to 0, out_valid=0 next cycle.
  - Same-cycle push is dropped; flush has priority over push and pop.
- Decode is purely combinational from the head storage entry; outputs hold while out_valid=1 and out_ready=0.
- Format table (opcode -> fmt):
  - 00000 -> R.
  - 00010, 00101, 00110, 00111, 01000 -> I.
  - 00001, 00011, 10101, 10110 -> JI.
  - 00100 -> JII.
  - Any other opcode: illegal=1, fmt=R.
- For R-format, aluop is as extracted; for other formats all fields are still extracted raw.
- Reset asserted mid-operation discards all contents immediately.

Optional Feature:
- Macro DECODE_STATS_EN.
- When defined, adds outputs stat_accepted[31:0] and stat_illegal[31:0].
  - stat_accepted increments on every push.
  - stat_illegal increments on every pop whose head has illegal=1.
  - Both counters wrap at 2^32, clear on reset and are NOT cleared by flush.
- When undefined, these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=1, opcode=0, fmt=0, illegal=0.
- Push 0x2845FFFF (addi), out_ready=0:
  - next cycle: out_valid=1, opcode=5, rd=1, rs=2, imm_sext=0xFFFFFFFF, fmt=1.
  - fields hold for 3 cycles.
- Push 0x00C22000, then 0x08000100, out_ready=1:
  - first pop: rd=3, rs=1, rt=2, fmt=0.
  - second pop: opcode=1, target=0x100, fmt=2.
- Push 4 words with out_ready=0:
  - in_ready=0 after the 4th; a 5th offer is not accepted.
  - Then pop one with in_valid held: in_ready rises the cycle after the pop, and FIFO order is preserved across pointer wrap.
- Fill 3 entries, assert flush together with in_valid -> out_valid=0 next cycle, count=0, the flushed-cycle word is absent.
- Push 0x69525 2A9 (opcode 01101) -> illegal=1, fmt=0.
  - With DECODE_STATS_EN: after the pop, stat_illegal=1 and stat_accepted is incremented.
